// File: rtl/sample_server_if.sv
// Producer/consumer handshake bundle for sample_server.
interface sample_server_if #(
    parameter int DATA_BW = 8
);
    logic               i_wr;
    logic [DATA_BW-1:0] i_wdata;
    logic               o_wr_rdy;
    logic               o_start_p;
    logic               i_rd;
    logic               o_rdy;
    logic [DATA_BW-1:0] o_rdata;
    logic               o_done_p;
    logic               i_abort;
    logic               o_wr_drop;
    logic               i_clr;

    modport slave (
        input  i_wr, i_wdata, i_rd, i_abort, i_clr,
        output o_wr_rdy, o_start_p, o_rdy, o_rdata, o_done_p, o_wr_drop
    );

    modport master (
        output i_wr, i_wdata, i_rd, i_abort, i_clr,
        input  o_wr_rdy, o_start_p, o_rdy, o_rdata, o_done_p, o_wr_drop
    );
endinterface

// File: rtl/sample_server.sv
// Block sample buffer: accepts DEPTH samples, then serves them in address
// order through an RD_LAT-deep read pipeline; abort returns to filling.
module sample_server #(
    parameter int DATA_BW = 8,
    parameter int DEPTH   = 256,
    parameter int RD_LAT  = 1
) (
    input  logic           i_clk,
    input  logic           reset_n,
    sample_server_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, START, SERVE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [DATA_BW-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      wr_cnt, rd_cnt, ret_cnt;
    logic               wr_drop;

    logic               rd_vld_p  [RD_LAT];
    logic [DATA_BW-1:0] rd_data_p [RD_LAT];

    logic wr_acc, wr_bad, rd_issue, out_rdy, last_ret;

    always_comb begin
        wr_acc   = bus.i_wr && (state == FILL);
        wr_bad   = bus.i_wr && (state != FILL);
        rd_issue = bus.i_rd && (state == SERVE) && !bus.i_abort;
        // An abort hides a sample already at the output as well as those behind it
        out_rdy  = rd_vld_p[RD_LAT-1] && !bus.i_abort;
        last_ret = out_rdy && (state == DRAIN) && (ret_cnt == CNT_LAST);
    end

    always_comb begin
        state_nxt     = state;
        bus.o_wr_rdy  = 1'b0;
        bus.o_start_p = 1'b0;
        bus.o_done_p  = 1'b0;
        case (state)
            FILL: begin
                bus.o_wr_rdy = 1'b1;
                if (wr_acc && (wr_cnt == CNT_LAST)) state_nxt = START;
            end
            START: begin
                bus.o_start_p = !bus.i_abort;
                state_nxt     = SERVE;
            end
            SERVE: begin
                if (rd_issue && (rd_cnt == CNT_LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_ret) begin
                    bus.o_done_p = 1'b1;
                    state_nxt    = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        if (bus.i_abort) state_nxt = FILL;
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) state <= FILL;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            ret_cnt <= '0;
        end else if (bus.i_abort || last_ret) begin
            wr_ptr  <= '0;
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            ret_cnt <= '0;
        end else begin
            if (wr_acc && (wr_cnt != CNT_FULL)) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (state == START) begin
                rd_ptr  <= '0;
                rd_cnt  <= '0;
                ret_cnt <= '0;
            end else begin
                if (rd_issue && (rd_cnt != CNT_FULL)) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (out_rdy && (ret_cnt != CNT_FULL)) ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    // A new drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n)       wr_drop <= 1'b0;
        else if (wr_bad)    wr_drop <= 1'b1;
        else if (bus.i_clr) wr_drop <= 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.i_wdata;
    end

    // Read pipeline: stage p0 captures the issued address, last stage drives o_rdy
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld_p[i]  <= 1'b0;
                rd_data_p[i] <= '0;
            end
        end else begin
            rd_vld_p[0]  <= rd_issue;
            rd_data_p[0] <= mem[rd_ptr];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i]  <= rd_vld_p[i-1] && !bus.i_abort;
                rd_data_p[i] <= rd_data_p[i-1];
            end
        end
    end

    assign bus.o_rdy     = out_rdy;
    assign bus.o_rdata   = rd_data_p[RD_LAT-1];
    assign bus.o_wr_drop = wr_drop;
endmodule

// File: tb/tb_sample_server.sv
// Four sample_server variants share one stimulus stream and are checked
// against a cycle-level behavioural model plus directed scenarios.
module tb_sample_server;
    localparam int NI = 4;
    localparam int PH_FILL  = 0;
    localparam int PH_START = 1;
    localparam int PH_SERVE = 2;
    localparam int PH_DRAIN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr = 1'b0, rd = 1'b0, abort = 1'b0, clr = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [NI-1:0]      o_wr_rdy_v, o_start_v, o_rdy_v, o_done_v, o_drop_v;
    logic [NI-1:0][7:0] o_rdata_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GD = (g == 3) ? 4 : 256;
        localparam int GL = (g == 3) ? 2 : g + 1;
        sample_server_if #(.DATA_BW(8)) bus ();
        assign bus.i_wr    = wr;
        assign bus.i_wdata = wdata;
        assign bus.i_rd    = rd;
        assign bus.i_abort = abort;
        assign bus.i_clr   = clr;
        sample_server #(.DATA_BW(8), .DEPTH(GD), .RD_LAT(GL)) dut (
            .i_clk   (clk),
            .reset_n (rst_n),
            .bus     (bus.slave)
        );
        assign o_wr_rdy_v[g] = bus.o_wr_rdy;
        assign o_start_v[g]  = bus.o_start_p;
        assign o_rdy_v[g]    = bus.o_rdy;
        assign o_done_v[g]   = bus.o_done_p;
        assign o_drop_v[g]   = bus.o_wr_drop;
        assign o_rdata_v[g]  = bus.o_rdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: block contents, fill/issue/return counts, return times
    int         dep_m [NI] = '{256, 256, 256, 4};
    int         lat_m [NI] = '{1, 2, 3, 2};
    int         cyc = 0;
    int         phase [NI];
    int         fill_n [NI], iss_n [NI], ret_n [NI];
    bit         drop_m [NI];
    logic [7:0] mem_m [NI][256];
    int         due_m [NI][256];

    int         n_rdy [NI], n_done [NI], first_rdy [NI], last_rdy [NI];
    logic [7:0] done_data [NI];

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       a;
        logic [3:0] e;
        logic [7:0] ed;
    } vec_t;
    vec_t tbl [17];

    function automatic vec_t mk(logic w, logic [7:0] d, logic r, logic a,
                                logic [3:0] e, logic [7:0] ed);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.a = a; v.e = e; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        bit due, e_rdy, e_done;
        int ph;
        ph     = phase[k];
        due    = (ret_n[k] < iss_n[k]) && (due_m[k][ret_n[k]] == cyc);
        e_rdy  = due && !abort;
        e_done = e_rdy && (ret_n[k] == dep_m[k] - 1);
        check($sformatf("ctl%0d@%0d", k, cyc),
              32'({o_wr_rdy_v[k], o_start_v[k], o_rdy_v[k], o_done_v[k], o_drop_v[k]}),
              32'({ph == PH_FILL, (ph == PH_START) && !abort, e_rdy, e_done, drop_m[k]}));
        if (e_rdy)
            check($sformatf("rdata%0d@%0d", k, cyc), 32'(o_rdata_v[k]), 32'(mem_m[k][ret_n[k]]));
        if (o_rdy_v[k]) begin
            n_rdy[k]++;
            if (first_rdy[k] < 0) first_rdy[k] = cyc;
            last_rdy[k] = cyc;
        end
        if (o_done_v[k]) begin
            n_done[k]++;
            done_data[k] = o_rdata_v[k];
        end
        if (wr && ph != PH_FILL) drop_m[k] = 1'b1;
        else if (clr)            drop_m[k] = 1'b0;
        if (abort) begin
            phase[k] = PH_FILL; fill_n[k] = 0; iss_n[k] = 0; ret_n[k] = 0;
            return;
        end
        if (e_rdy) begin
            ret_n[k]++;
            if (e_done) begin
                phase[k] = PH_FILL; fill_n[k] = 0; iss_n[k] = 0; ret_n[k] = 0;
            end
        end
        case (ph)
            PH_FILL: if (wr) begin
                mem_m[k][fill_n[k]] = wdata;
                fill_n[k]++;
                if (fill_n[k] == dep_m[k]) phase[k] = PH_START;
            end
            PH_START: begin
                phase[k] = PH_SERVE; iss_n[k] = 0; ret_n[k] = 0;
            end
            PH_SERVE: if (rd) begin
                due_m[k][iss_n[k]] = cyc + lat_m[k];
                iss_n[k]++;
                if (iss_n[k] == dep_m[k]) phase[k] = PH_DRAIN;
            end
            default: ;
        endcase
    endtask

    task automatic neg();
        @(negedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        cyc++;
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        neg();
        pos();
    endtask

    task automatic do_reset();
        wr = 1'b0; rd = 1'b0; abort = 1'b0; clr = 1'b0; wdata = 8'h00;
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_rdy%0d", k),   32'(o_rdy_v[k]),    32'(0));
            check($sformatf("rst_rdata%0d", k), 32'(o_rdata_v[k]),  32'(0));
            check($sformatf("rst_start%0d", k), 32'(o_start_v[k]),  32'(0));
            check($sformatf("rst_done%0d", k),  32'(o_done_v[k]),   32'(0));
            check($sformatf("rst_drop%0d", k),  32'(o_drop_v[k]),   32'(0));
            check($sformatf("rst_wrrdy%0d", k), 32'(o_wr_rdy_v[k]), 32'(1));
            phase[k] = PH_FILL; fill_n[k] = 0; iss_n[k] = 0; ret_n[k] = 0;
            drop_m[k] = 1'b0;
            n_rdy[k] = 0; n_done[k] = 0; first_rdy[k] = -1; last_rdy[k] = -1;
            done_data[k] = 8'h00;
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_block(input int mode);
        for (int i = 0; i < 256; i++) begin
            wr = 1'b1;
            case (mode)
                0:       wdata = 8'(i);
                1:       wdata = 8'(i) ^ 8'h5A;
                2:       wdata = 8'(255 - i);
                default: wdata = 8'($urandom);
            endcase
            cycle();
        end
        wr = 1'b0;
        cycle();
    endtask

    initial begin
        int c0, snap;

        do_reset();

        // DEPTH=4, RD_LAT=2 instance: abort on the 4th write, then a full block
        tbl[0]  = mk(1, 8'h11, 0, 0, 4'b1000, 8'h00);
        tbl[1]  = mk(1, 8'h22, 0, 0, 4'b1000, 8'h00);
        tbl[2]  = mk(1, 8'h33, 0, 0, 4'b1000, 8'h00);
        tbl[3]  = mk(1, 8'h44, 0, 1, 4'b1000, 8'h00);
        tbl[4]  = mk(0, 8'h00, 0, 0, 4'b1000, 8'h00);
        tbl[5]  = mk(1, 8'h05, 0, 0, 4'b1000, 8'h00);
        tbl[6]  = mk(1, 8'h06, 0, 0, 4'b1000, 8'h00);
        tbl[7]  = mk(1, 8'h07, 0, 0, 4'b1000, 8'h00);
        tbl[8]  = mk(1, 8'h08, 0, 0, 4'b1000, 8'h00);
        tbl[9]  = mk(0, 8'h00, 1, 0, 4'b0100, 8'h00);
        tbl[10] = mk(0, 8'h00, 1, 0, 4'b0000, 8'h00);
        tbl[11] = mk(0, 8'h00, 1, 0, 4'b0000, 8'h00);
        tbl[12] = mk(0, 8'h00, 1, 0, 4'b0010, 8'h05);
        tbl[13] = mk(0, 8'h00, 1, 0, 4'b0010, 8'h06);
        tbl[14] = mk(0, 8'h00, 1, 0, 4'b0010, 8'h07);
        tbl[15] = mk(0, 8'h00, 0, 0, 4'b0011, 8'h08);
        tbl[16] = mk(0, 8'h00, 0, 0, 4'b1000, 8'h00);
        for (int i = 0; i < 17; i++) begin
            wr = tbl[i].w; wdata = tbl[i].d; rd = tbl[i].r; abort = tbl[i].a;
            neg();
            check($sformatf("tbl%0d", i),
                  32'({o_wr_rdy_v[3], o_start_v[3], o_rdy_v[3], o_done_v[3]}), 32'(tbl[i].e));
            if (tbl[i].e[1])
                check($sformatf("tbl_rdata%0d", i), 32'(o_rdata_v[3]), 32'(tbl[i].ed));
            pos();
        end
        abort = 1'b0; rd = 1'b0;

        // Continuous read on RD_LAT=1, with a dropped write and a clear mid-serve
        do_reset();
        fill_block(0);
        c0 = cyc;
        for (int i = 0; i < 262; i++) begin
            rd = 1'b1;
            wr = (i == 50);
            wdata = 8'hA5;
            clr = (i == 60);
            cycle();
            if (i == 50) check("drop_set", 32'(o_drop_v[0]), 32'(1));
            if (i == 60) check("drop_clr", 32'(o_drop_v[0]), 32'(0));
        end
        wr = 1'b0; clr = 1'b0; rd = 1'b0;
        check("a_nrdy",   32'(n_rdy[0]), 32'(256));
        check("a_first",  32'(first_rdy[0] - c0), 32'(1));
        check("a_span",   32'(last_rdy[0] - first_rdy[0]), 32'(255));
        check("a_ndone",  32'(n_done[0]), 32'(1));
        check("a_dlast",  32'(done_data[0]), 32'(255));
        check("a_wrrdy",  32'(o_wr_rdy_v[0]), 32'(1));

        // Alternating read requests on RD_LAT=3
        do_reset();
        fill_block(1);
        c0 = cyc;
        for (int i = 0; i < 530; i++) begin
            rd = ~i[0];
            cycle();
        end
        rd = 1'b0;
        check("b_nrdy",  32'(n_rdy[2]), 32'(256));
        check("b_first", 32'(first_rdy[2] - c0), 32'(3));
        check("b_span",  32'(last_rdy[2] - first_rdy[2]), 32'(510));
        check("b_ndone", 32'(n_done[2]), 32'(1));
        check("b_dlast", 32'(done_data[2]), 32'(8'hFF ^ 8'h5A));

        // Abort after 100 issued reads on RD_LAT=2, then a fresh block
        do_reset();
        fill_block(3);
        rd = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        snap = n_rdy[1];
        abort = 1'b1;
        cycle();
        abort = 1'b0; rd = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("c_nrdy_abort", 32'(n_rdy[1]), 32'(snap));
        check("c_ndone",      32'(n_done[1]), 32'(0));
        check("c_wrrdy",      32'(o_wr_rdy_v[1]), 32'(1));
        fill_block(3);
        for (int i = 0; i < 2000 && n_done[1] == 0; i++) begin
            rd = 1'($urandom);
            cycle();
        end
        rd = 1'b0;
        check("c_ndone2", 32'(n_done[1]), 32'(1));
        check("c_nrdy2",  32'(n_rdy[1]), 32'(snap + 256));

        // Asynchronous reset mid-serve, then a descending block
        do_reset();
        fill_block(0);
        rd = 1'b1;
        for (int i = 0; i < 50; i++) cycle();
        check("d_rdy_before", 32'(o_rdy_v[0]), 32'(1));
        do_reset();
        fill_block(2);
        rd = 1'b1;
        for (int i = 0; i < 262; i++) cycle();
        rd = 1'b0;
        check("d_nrdy",  32'(n_rdy[0]), 32'(256));
        check("d_dlast", 32'(done_data[0]), 32'(0));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wr    = ($urandom_range(3) != 0);
            wdata = 8'($urandom);
            rd    = 1'($urandom);
            abort = ($urandom_range(999) == 0);
            clr   = ($urandom_range(19) == 0);
            cycle();
        end
        wr = 1'b0; rd = 1'b0; abort = 1'b0; clr = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
